// File: rtl/fifo_rd_stage.sv
// fifo_rd_stage: FIFO read side with a Gray read pointer and a 2-entry registered output buffer.
// Define FIFO_RD_STAGE_LEVEL_EN to add the registered rlevel occupancy output.
module fifo_rd_stage #(
    parameter int DATASIZE = 8,
    parameter int ADDRSIZE = 4
) (
    input  logic                rclk,
    input  logic                rrst,
    input  logic [ADDRSIZE:0]   rq2_wptr,
    output logic [ADDRSIZE:0]   rptr,
    output logic [ADDRSIZE-1:0] raddr,
    output logic                rclken,
    input  logic [DATASIZE-1:0] mem_rdata,
    output logic                m_valid,
    input  logic                m_ready,
    output logic [DATASIZE-1:0] m_data,
    output logic                rempty
`ifdef FIFO_RD_STAGE_LEVEL_EN
    ,
    output logic [ADDRSIZE+1:0] rlevel
`endif
);
    logic [ADDRSIZE:0]   rbin, rbin_nxt;
    logic [1:0]          occ;
    logic                inflight, mem_empty, pop;
    logic [DATASIZE-1:0] tail;

    assign mem_empty = rptr == rq2_wptr;
    assign m_valid   = occ != 2'd0;
    assign pop       = m_valid && m_ready;
    assign raddr     = rbin[ADDRSIZE-1:0];
    // Issue a read only if its word is guaranteed a buffer slot when it lands
    assign rclken    = !rrst && !mem_empty && ({1'b0, occ} + {2'b0, inflight} - {2'b0, pop} < 3'd2);
    assign rbin_nxt  = rbin + {{ADDRSIZE{1'b0}}, rclken};
    assign rempty    = mem_empty && !inflight && occ == 2'd0;

    always_ff @(posedge rclk) begin
        if (rrst) begin
            rbin     <= '0;
            rptr     <= '0;
            inflight <= 1'b0;
            occ      <= 2'd0;
            m_data   <= '0;
            tail     <= '0;
        end else begin
            rbin     <= rbin_nxt;
            rptr     <= rbin_nxt ^ (rbin_nxt >> 1);
            inflight <= rclken;
            occ      <= occ + {1'b0, inflight} - {1'b0, pop};
            if (pop)
                m_data <= (occ == 2'd2) ? tail : mem_rdata;
            else if (inflight && occ == 2'd0)
                m_data <= mem_rdata;
            if (inflight && ((occ == 2'd2 && pop) || (occ == 2'd1 && !pop)))
                tail <= mem_rdata;
        end
    end

`ifdef FIFO_RD_STAGE_LEVEL_EN
    function automatic logic [ADDRSIZE:0] gray2bin(input logic [ADDRSIZE:0] g);
        for (int i = ADDRSIZE - 1; i >= 0; i--)
            g[i] = g[i] ^ g[i+1];
        return g;
    endfunction

    always_ff @(posedge rclk) begin
        if (rrst)
            rlevel <= '0;
        else
            rlevel <= {1'b0, gray2bin(rq2_wptr) - rbin} + {{(ADDRSIZE+1){1'b0}}, inflight} + {{ADDRSIZE{1'b0}}, occ};
    end
`endif
endmodule

// File: tb/tb_fifo_rd_stage.sv
// tb_fifo_rd_stage: randomized and directed checks of fifo_rd_stage against a word-count model.
// Define FIFO_RD_STAGE_LEVEL_EN to also check rlevel.
module tb_fifo_rd_stage;
    localparam int AW = 4;

    logic          rclk = 1'b0, rrst = 1'b1, m_ready = 1'b0;
    logic          rclken, m_valid, rempty;
    logic [AW:0]   rq2_wptr = '0, rptr;
    logic [AW-1:0] raddr;
    logic [7:0]    mem_rdata = '0, m_data;
    logic [7:0]    mem [16];
    logic [7:0]    dat [256];
    int            mw = 0, mr = 0, mp = 0, ml = 0, npop = 0, tests = 0, fails = 0;
    int            occ_m, er, pe;
`ifdef FIFO_RD_STAGE_LEVEL_EN
    logic [AW+1:0] rlevel;
`endif

    fifo_rd_stage dut (
        .rclk(rclk), .rrst(rrst), .rq2_wptr(rq2_wptr), .rptr(rptr), .raddr(raddr),
        .rclken(rclken), .mem_rdata(mem_rdata), .m_valid(m_valid), .m_ready(m_ready),
        .m_data(m_data), .rempty(rempty)
`ifdef FIFO_RD_STAGE_LEVEL_EN
        , .rlevel(rlevel)
`endif
    );

    always #5 rclk = ~rclk;

    always @(posedge rclk) if (rclken) mem_rdata <= mem[raddr];

    function automatic logic [4:0] gray(input int b);
        logic [4:0] v;
        v = b[4:0];
        return v ^ (v >> 1);
    endfunction

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", n, a, e);
        end
    endtask

    task automatic step;
        @(posedge rclk);
        #1;
    endtask

    task automatic wr(input logic [7:0] v);
        mem[mw % 16] = v;
        dat[mw] = v;
        mw++;
        rq2_wptr = gray(mw);
    endtask

    task automatic do_reset;
        rrst = 1'b1;
        mw = 0;
        rq2_wptr = '0;
        step;
        rrst = 1'b0;
    endtask

    // Model: mw written, mr read, mp popped, ml = read issued last cycle (still in flight)
    always @(negedge rclk) begin
        occ_m = mr - mp - ml;
        pe = (occ_m > 0 && m_ready) ? 1 : 0;
        er = (!rrst && mr != mw && (mr - mp - pe) < 2) ? 1 : 0;
        chk("rclken", rclken, er);
        if (rrst) begin
            mr = 0;
            mp = 0;
            ml = 0;
        end else begin
            chk("m_valid", m_valid, occ_m > 0);
            chk("rptr", rptr, gray(mr));
            chk("raddr", raddr, mr % 16);
            chk("rempty", rempty, mw == mp);
            if (occ_m > 0) chk("m_data", m_data, dat[mp]);
            if (m_valid && m_ready) npop++;
            mp += pe;
            ml = er;
            mr += er;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1);
    end

    initial begin
        int n, first, last, saw15, p0, w, c;
        repeat (2) step;
        @(negedge rclk);
        chk("rst_rptr", rptr, 0);
        chk("rst_valid", m_valid, 0);
        chk("rst_data", m_data, 0);
        chk("rst_rempty", rempty, 1);
        chk("rst_rclken", rclken, 0);
        step;
        rrst = 1'b0;
        step;

        wr(8'hA5);
        @(negedge rclk);
        chk("sw_rclken", rclken, 1);
        chk("sw_raddr", raddr, 0);
        step;
        @(negedge rclk);
        chk("sw_rclken_off", rclken, 0);
        chk("sw_rptr", rptr, 5'b00001);
        chk("sw_valid_n1", m_valid, 0);
        chk("sw_rempty", rempty, 0);
        step;
        @(negedge rclk);
        chk("sw_valid_n2", m_valid, 1);
        chk("sw_data", m_data, 8'hA5);
        chk("sw_rempty2", rempty, 0);
        step;
        m_ready = 1'b1;
        @(negedge rclk);
        chk("sw_valid_hold", m_valid, 1);
        step;
        @(negedge rclk);
        chk("sw_popped", m_valid, 0);
        chk("sw_rempty_end", rempty, 1);
        step;
        m_ready = 1'b0;

        for (int i = 0; i < 4; i++) wr(8'(8'h10 + i));
        repeat (6) step;
        @(negedge rclk);
        chk("bp_rclken", rclken, 0);
        chk("bp_rptr", rptr, 5'b00010);
        chk("bp_data", m_data, 8'h10);
        step;
        m_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge rclk);
            chk("bp_valid", m_valid, 1);
            chk("bp_word", m_data, 8'h10 + i);
            step;
        end
        @(negedge rclk);
        chk("bp_rempty", rempty, 1);
        step;

        do_reset;
        m_ready = 1'b1;
        for (int i = 0; i < 16; i++) wr(8'(i * 7 + 3));
        n = 0; first = -1; last = -1; saw15 = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge rclk);
            if (rclken && raddr == 4'd15) saw15 = 1;
            if (m_valid) begin
                n++;
                if (first < 0) first = k;
                last = k;
            end
            step;
        end
        chk("st_count", n, 16);
        chk("st_consec", last - first + 1, 16);
        chk("st_raddr15", saw15, 1);
        @(negedge rclk);
        chk("st_rptr", rptr, 5'b11000);
        chk("st_rempty", rempty, 1);
        step;

        m_ready = 1'b0;
        for (int i = 0; i < 4; i++) wr(8'(8'hC0 + i));
        step;
        step;
        rrst = 1'b1;
        mw = 0;
        rq2_wptr = '0;
        @(negedge rclk);
        chk("rs_pre_valid", m_valid, 1);
        step;
        rrst = 1'b0;
        @(negedge rclk);
        chk("rs_valid", m_valid, 0);
        chk("rs_rptr", rptr, 0);
        chk("rs_rempty", rempty, 1);
        chk("rs_data", m_data, 0);
        step;
        @(negedge rclk);
        chk("rs_valid2", m_valid, 0);
        step;

        p0 = npop;
        w = 0;
        for (int k = 0; k < 3000 && npop - p0 < 40; k++) begin
            m_ready = 1'($urandom_range(0, 1));
            if (w < 40 && mw - mr < 16 && $urandom_range(0, 2) != 0) begin
                wr(8'($urandom));
                w++;
            end
            step;
        end
        m_ready = 1'b0;
        @(negedge rclk);
        chk("wr_pops", npop - p0, 40);
        chk("wr_rempty", rempty, 1);
        chk("wr_rptr", rptr, rq2_wptr);
        step;

`ifdef FIFO_RD_STAGE_LEVEL_EN
        do_reset;
        for (int i = 0; i < 7; i++) wr(8'(8'h50 + i));
        repeat (4) step;
        m_ready = 1'b1;
        c = 0;
        for (int k = 0; k < 20 && c < 3; k++) begin
            @(negedge rclk);
            if (m_valid) c++;
            step;
        end
        m_ready = 1'b0;
        repeat (6) step;
        @(negedge rclk);
        chk("lvl_pops", c, 3);
        chk("lvl_rlevel", rlevel, 4);
        step;
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
